// File: rtl/clm_digit_serial_multiplier_pkg.sv
// Shared types for the CLM digit-serial multiplier datapath.
// Element, reduction-vector and matrix typedefs are sized for the default
// redundancy degree; width helpers derive the same quantities for any D.
package clm_digit_serial_multiplier_pkg;

  localparam int CLM_D     = 4;
  localparam int CLM_W     = 8 + CLM_D;      // element width (8+D)
  localparam int CLM_V_W   = 7 + 2 * CLM_D;  // {r, ovf} reduction input width
  localparam int CLM_ACC_W = 15 + 2 * CLM_D; // full product width

  typedef logic [CLM_W-1:0]            state_t;
  typedef logic [CLM_V_W-1:0]          red_poly_t;
  typedef logic [7:0][CLM_V_W-1:0]     mul_m_matrix_t;
  typedef logic [CLM_ACC_W-1:0]        clm_acc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } clm_mul_state_t;

  // Accumulator width for redundancy degree d (product degree <= 14+2d).
  function automatic int clm_acc_width(input int d);
    return 15 + 2 * d;
  endfunction

  // Number of accumulation cycles: ceil((8+d)/digit).
  function automatic int clm_ncyc(input int d, input int digit);
    return (8 + d + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/clm_sys_reduce.sv
// Systematic-encoder reduction term for CLM elements.
// Output bits 0..7 are parities of v = {ovf, r} against the matrix columns;
// the upper D bits carry the refresh randomness r directly.
module clm_sys_reduce
  import clm_digit_serial_multiplier_pkg::*;
#(
  parameter int D = 4
) (
  input  logic [6+D:0]          ovf,
  input  logic [D-1:0]          r,
  input  logic [7:0][6+2*D:0]   b_ext,
  output logic [7+D:0]          red
);

  logic [6+2*D:0] v;

  // r sits in the low positions of v, overflow coefficients above it.
  assign v = {ovf, r};

  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    assign red[gi] = ^(v & b_ext[gi]);
  end

  assign red[7+D:8] = r;

endmodule

// File: rtl/clm_digit_serial_multiplier.sv
// Digit-serial CLM GF(2^8) multiplier with systematic reduction and refresh.
// Consumes DIGIT bits of p2 per cycle, then reduces modulo PQ in one cycle.
// Optional build macro: CLM_MUL_ZEROIZE_EN clears operands, accumulator and
// output on the output handshake.
module clm_digit_serial_multiplier
  import clm_digit_serial_multiplier_pkg::*;
#(
  parameter int D     = 4,
  parameter int DIGIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7+D:0]          p1,
  input  logic [7+D:0]          p2,
  input  logic [D-1:0]          r,
  input  logic [7:0][6+2*D:0]   B_ext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7+D:0]          out
);

  localparam int W     = 8 + D;
  localparam int ACC_W = clm_acc_width(D);
  localparam int NCYC  = clm_ncyc(D, DIGIT);
  localparam int KW    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCYC - 1);

  clm_mul_state_t   state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [ACC_W-1:0] p1_sh_q, p1_sh_d;   // p1 pre-shifted to the current digit position
  logic [W-1:0]     p2_sh_q, p2_sh_d;   // p2 with consumed digits shifted out
  logic [D-1:0]     r_q, r_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [W-1:0]     out_q, out_d;

  logic [ACC_W-1:0] digit_sum;
  logic [W-1:0]     red;

  // Partial product of the current digit. Zeros shifted into p2 beyond bit
  // W-1 mask the tail of the last digit, so no out-of-range terms appear.
  always_comb begin
    digit_sum = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (p2_sh_q[j]) begin
        digit_sum = digit_sum ^ (p1_sh_q << j);
      end
    end
  end

  clm_sys_reduce #(.D(D)) u_reduce (
    .ovf   (acc_q[ACC_W-1:W]),
    .r     (r_q),
    .b_ext (B_ext),
    .red   (red)
  );

  // FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p1_sh_d = p1_sh_q;
    p2_sh_d = p2_sh_q;
    r_d     = r_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          p1_sh_d = ACC_W'(p1);
          p2_sh_d = p2;
          r_d     = r;
          acc_d   = '0;
          k_d     = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d   = acc_q ^ digit_sum;
        p1_sh_d = p1_sh_q << DIGIT;
        p2_sh_d = p2_sh_q >> DIGIT;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        out_d   = acc_q[W-1:0] ^ red;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef CLM_MUL_ZEROIZE_EN
          acc_d   = '0;
          p1_sh_d = '0;
          p2_sh_d = '0;
          r_d     = '0;
          out_d   = '0;
`else
          // Registers keep their contents; out holds the last result.
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      p1_sh_q <= '0;
      p2_sh_q <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p1_sh_q <= p1_sh_d;
      p2_sh_q <= p2_sh_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_clm_digit_serial_multiplier.sv
// Bench for the digit-serial CLM multiplier: instance A (D=4, DIGIT=1) runs a
// hand-computed vector table, backpressure, zeroisation and reset cases;
// instance B (D=3, DIGIT=4) checks the masked last digit and random ops
// against a direct product-plus-reduction model.
module tb_clm_digit_serial_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A: D=4, DIGIT=1 ----------------
  logic              a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [11:0]       a_p1, a_p2, a_out;
  logic [3:0]        a_r;
  logic [7:0][14:0]  a_bext;

  clm_digit_serial_multiplier #(.D(4), .DIGIT(1)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .p1(a_p1), .p2(a_p2), .r(a_r), .B_ext(a_bext),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
  );

  // ---------------- instance B: D=3, DIGIT=4 ----------------
  logic              b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [10:0]       b_p1, b_p2, b_out;
  logic [2:0]        b_r;
  logic [7:0][12:0]  b_bext;

  clm_digit_serial_multiplier #(.D(3), .DIGIT(4)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .p1(b_p1), .p2(b_p2), .r(b_r), .B_ext(b_bext),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
  );

  typedef struct {
    logic [11:0] p1;
    logic [11:0] p2;
    logic [3:0]  r;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Product plus systematic reduction for D=3, straight from the definition.
  function automatic logic [10:0] model_b(input logic [10:0] a, input logic [10:0] b,
                                          input logic [2:0] rr, input logic [7:0][12:0] m);
    logic [20:0] acc;
    logic [12:0] v;
    logic [10:0] red;
    acc = '0;
    for (int i = 0; i < 11; i++) begin
      if (b[i]) acc = acc ^ (21'(a) << i);
    end
    v   = {acc[20:11], rr};
    red = '0;
    for (int i = 0; i < 8; i++) red[i] = ^(v & m[i]);
    red[10:8] = rr;
    return acc[10:0] ^ red;
  endfunction

  task automatic op_a(input logic [11:0] a, input logic [11:0] b, input logic [3:0] rr,
                      output logic [11:0] res, output int lat);
    @(negedge clk);
    a_p1 = a; a_p2 = b; a_r = rr; a_in_valid = 1'b1;
    chk("a_in_ready_at_issue", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = a_out;
  endtask

  task automatic hs_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("a_hs_out_valid", a_out_valid, 0);
    chk("a_hs_in_ready", a_in_ready, 1);
  endtask

  task automatic op_b(input logic [10:0] a, input logic [10:0] b, input logic [2:0] rr,
                      output logic [10:0] res, output int lat);
    @(negedge clk);
    b_p1 = a; b_p2 = b; b_r = rr; b_in_valid = 1'b1;
    chk("b_in_ready_at_issue", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b_out;
  endtask

  task automatic hs_b();
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("b_hs_out_valid", b_out_valid, 0);
  endtask

  initial begin
    logic [11:0] res_a;
    logic [10:0] res_b, exp_b;
    int          lat;
    bit          seen;

    // Identity columns: red[i] = v[i], i.e. red[7:0] = {ovf[7-D:0], r}.
    vecs[0] = '{12'h001, 12'h0A5, 4'h0, 12'h0A5};
    vecs[1] = '{12'h001, 12'h0A5, 4'h3, 12'h3A6};
    vecs[2] = '{12'h002, 12'h800, 4'h0, 12'h010};
    vecs[3] = '{12'hFFF, 12'h001, 4'h0, 12'hFFF};
    vecs[4] = '{12'h003, 12'h003, 4'hA, 12'hA0F};
    vecs[5] = '{12'h100, 12'h110, 4'h5, 12'h515};
    vecs[6] = '{12'h0F0, 12'h0F0, 4'h0, 12'h550};
    vecs[7] = '{12'h000, 12'hFFF, 4'hF, 12'hF0F};
    vecs[8] = '{12'hFFF, 12'hFFF, 4'h0, 12'h505};

    a_rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_p1 = '0; a_p2 = '0; a_r = '0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_p1 = '0; b_p2 = '0; b_r = '0;
    for (int i = 0; i < 8; i++) begin
      a_bext[i] = 15'(1) << i;
      b_bext[i] = 13'(1) << i;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("a_reset_in_ready", a_in_ready, 1);
    chk("a_reset_out_valid", a_out_valid, 0);
    chk("a_reset_out", a_out, 0);
    chk("b_reset_in_ready", b_in_ready, 1);
    chk("b_reset_out_valid", b_out_valid, 0);

    // Table-driven vectors on A, latency NCYC+1 = 13.
    for (int v = 0; v < 9; v++) begin
      op_a(vecs[v].p1, vecs[v].p2, vecs[v].r, res_a, lat);
      chk($sformatf("a_vec%0d_latency", v), lat, 13);
      chk($sformatf("a_vec%0d_out", v), res_a, vecs[v].exp);
      hs_a();
    end

    // After the last handshake: zeroised build clears out, default build holds it.
`ifdef CLM_MUL_ZEROIZE_EN
    chk("a_out_after_hs", a_out, 12'h000);
`else
    chk("a_out_after_hs", a_out, 12'h505);
`endif

    // Backpressure: hold out_ready low 20 cycles with in_valid pulses.
    op_a(12'h001, 12'h0A5, 4'h3, res_a, lat);
    chk("a_bp_first_out", res_a, 12'h3A6);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_in_valid = c[0];
      a_p1 = 12'(c + 7); a_p2 = 12'hFFF; a_r = 4'(c);
      @(posedge clk); #1;
      chk($sformatf("a_bp_cycle%0d", c), {a_out_valid, a_in_ready, a_out}, {1'b1, 1'b0, 12'h3A6});
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    hs_a();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen = 1'b1;
    end
    chk("a_bp_no_ghost_op", seen, 0);

    // Reset during ACC at k=2: operation discarded.
    op_a(12'h0F0, 12'h0F0, 4'h0, res_a, lat);
    chk("a_prerst_out", res_a, 12'h550);
    hs_a();
    @(negedge clk);
    a_p1 = 12'h123; a_p2 = 12'hFFF; a_r = 4'h9; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    a_rst = 1'b1;
    #1;
    chk("a_rst_async_out_valid", a_out_valid, 0);
    chk("a_rst_async_out", a_out, 0);
    @(posedge clk); #2;
    a_rst = 1'b0;
    #1;
    chk("a_rst_in_ready", a_in_ready, 1);
    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_out", a_out, 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen = 1'b1;
    end
    chk("a_rst_no_stale_result", seen, 0);

    // B: masked last digit (p2 bit 10 only), identity matrix.
    op_b(11'h001, 11'h400, 3'h0, res_b, lat);
    chk("b_mask_latency", lat, 4);
    chk("b_mask_out_x10", res_b, 11'h400);
    hs_b();
    op_b(11'h7FF, 11'h400, 3'h0, res_b, lat);
    chk("b_mask_out_full_p1", res_b, 11'h4F8);
    hs_b();

    // B: random operands and matrices against the model.
    for (int n = 0; n < 40; n++) begin
      logic [10:0] a, b;
      logic [2:0]  rr;
      a  = 11'($urandom_range(0, 2047));
      b  = 11'($urandom_range(0, 2047));
      rr = 3'($urandom_range(0, 7));
      @(negedge clk);
      for (int i = 0; i < 8; i++) b_bext[i] = 13'($urandom_range(0, 8191));
      exp_b = model_b(a, b, rr, b_bext);
      op_b(a, b, rr, res_b, lat);
      chk($sformatf("b_rand%0d_latency", n), lat, 4);
      chk($sformatf("b_rand%0d_out", n), res_b, exp_b);
      hs_b();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clm_digit_serial_multiplier.md
# clm_digit_serial_multiplier

Sequential, parametrised successor to the combinational CLM multiplier. Multiplies two CLM-encoded GF(2^8) elements (8+D coefficients each) by accumulating DIGIT bits of the second operand per cycle. After the last digit it performs one cycle of systematic-encoder reduction modulo PQ, injecting fresh refresh randomness r. It sits in the CLM datapath wherever area matters more than single-cycle throughput, behind a valid/ready handshake.

## Interface
- D, 4: redundancy degree; elements are 8+D bits, r is D bits; D ≥ 1.
- DIGIT, 1: operand-2 bits consumed per cycle; 1 ≤ DIGIT ≤ 8+D; NCYC = ceil((8+D)/DIGIT).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- p1, p2  in  8+D  CLM operands; bit i = coefficient of x^i.
- r  in  D  refresh randomness, sampled with the operands.
- B_ext  in  (7+2D)×8  systematic encoder matrix; quasi-static, must be stable from acceptance until the output handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  8+D  reduced, refreshed product.

## Operation
- FSM states: IDLE, ACC, REDUCE, DONE.
- IDLE: in_ready=1. On in_valid, the block latches p1, p2, r, clears the accumulator, sets digit counter k=0, and goes to ACC.
- ACC: each cycle, acc ^= Σ over j<DIGIT of (p1 << (k·DIGIT+j)), taking only bits where p2[k·DIGIT+j]=1 and k·DIGIT+j < 8+D (the last digit is masked). Then k++. After NCYC cycles, go to REDUCE.
- Accumulator width is 15+2D bits (degree ≤ 14+2D). No truncation occurs during accumulation.
- REDUCE: ovf = acc[8+D .. 14+2D] (7+D bits). Concatenate v = {r, ovf}, 7+2D bits, with r in the low positions.
  - For i<8: red[i] = parity(v & B_ext column i).
  - red[8..7+D] = r.
  - Register out = acc[0..7+D] ^ red, then go to DONE.
- DONE: out_valid=1 and out is held stable. On out_ready, go to IDLE.
- in_ready=0 in ACC, REDUCE and DONE; in_valid there is ignored.
- No simultaneous accept-and-emit: a new operation starts only from IDLE.
- Reset (any state, asynchronous):
  - State goes to IDLE; in_ready=1 after deassertion.
  - out_valid=0 and out=0.
  - The accumulator, operand registers and counter are cleared. An in-flight operation is discarded with no output.

## Timing
- Acceptance edge: the rising edge with in_valid & in_ready.
- out_valid rises exactly NCYC+1 edges after the acceptance edge (NCYC in ACC, 1 in REDUCE).
  - D=4, DIGIT=1: 13 edges.
  - D=4, DIGIT=4: 4 edges.
- Output handshake at edge e (out_valid & out_ready): out_valid=0 and in_ready=1 after e. The next acceptance is possible at e+1.
- Minimum initiation interval: NCYC+3 cycles.
- out holds its last value after the handshake until the next REDUCE, unless zeroisation is enabled.

## Configuration
- CLM_MUL_ZEROIZE_EN
  - Defined: on the output handshake edge, acc, latched p1/p2/r and out are cleared to 0. out reads 0 whenever out_valid=0. This limits leakage of secret intermediates.
  - Undefined: registers retain their last values until overwritten; out holds the last result.
  - Latency is identical in both builds.

## Structure
- Shared types package: add
  - a D-parametrised accumulator type (15+2D bits);
  - the NCYC localparam derivation;
  - FSM state enum clm_mul_state_t.
- Existing state_t, red_poly_t and mul_m_matrix_t are reused for ports.
- One sub-module: clm_sys_reduce, a combinational module taking ovf, r and B_ext and producing the 8+D-bit reduction term. It is reusable by the combinational multiplier.

## Test plan
- D=4, DIGIT=1: p1=0x001 (x^0), p2=0x0A5, r=0, B_ext arbitrary -> out=0x0A5, out_valid exactly 13 edges after acceptance.
- D=4, DIGIT=4: random p1, p2, r and B_ext over 1000 ops -> out matches a golden model of the full product plus systematic reduction; latency 4 edges.
- D=3, DIGIT=4 (NCYC=3, masked last digit): p2 bit 10 set, other bits zero -> only the p1<<10 contribution appears; no p1<<11 term.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out stay stable, in_ready=0, in_valid pulses ignored; release -> in_ready=1 on the next cycle.
- Assert rst during ACC at k=2 -> out_valid=0, out=0, in_ready=1 after deassertion; no stale result is emitted afterwards.
- Zeroisation build: after the output handshake -> out=0 and internal acc=0 next cycle. Non-zeroisation build: out retains the result.
